// File: rtl/pc_gen.sv
// Fetch-stage program counter with exception/ERET entry and a one-entry
// pending-redirect buffer that holds a branch/jump target across a stall.
module pc_gen #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] PC_INIT = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h0000_4180),
  parameter int               STEP    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             UpdateEn,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] PC_current,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pend_valid,
  output logic             pc_misaligned
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pend_tgt;
  logic             r_pend_vld;

  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pend_tgt_nxt;
  logic             w_pend_vld_nxt;
  logic [WIDTH-1:0] w_pc_plus;

  assign w_pc_plus = r_pc + WIDTH'(STEP);

  // Exception and ERET bypass the stall; a fresh redirect supersedes the buffer.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pend_vld_nxt = r_pend_vld;
    if (exc_req) begin
      w_pc_nxt       = EXC_VEC;
      w_pend_vld_nxt = 1'b0;
    end else if (eret_req) begin
      w_pc_nxt       = epc;
      w_pend_vld_nxt = 1'b0;
    end else if (UpdateEn) begin
      w_pend_vld_nxt = 1'b0;
      if (redir_valid)
        w_pc_nxt = redir_target;
      else if (r_pend_vld)
        w_pc_nxt = r_pend_tgt;
      else
        w_pc_nxt = w_pc_plus;
    end else if (redir_valid) begin
      w_pend_tgt_nxt = redir_target;
      w_pend_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= PC_INIT;
      r_pend_tgt <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_pend_vld <= w_pend_vld_nxt;
    end
  end

  assign PC_current    = r_pc;
  assign pc_plus       = w_pc_plus;
  assign pend_valid    = r_pend_vld;
  assign pc_misaligned = |r_pc[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a 32-bit default instance and an 8-bit wrap instance
// share one control stream and are compared against a priority-rule model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, UpdateEn, redir_valid, exc_req, eret_req;
  logic [31:0] redir_target, epc;

  logic [31:0] pc32, plus32;
  logic        pend32, mis32;
  logic [7:0]  pc8, plus8;
  logic        pend8, mis8;

  int tests = 0;
  int fails = 0;

  // model state: index 0 = 32-bit instance, index 1 = 8-bit instance
  logic [31:0] m_pc   [2];
  logic [31:0] m_tgt  [2];
  logic        m_pend [2];
  logic [31:0] m_mask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] m_init [2] = '{32'h0000_3000, 32'h0000_00F8};
  logic [31:0] m_vec  [2] = '{32'h0000_4180, 32'h0000_0080};

  always #5 clk = ~clk;

  pc_gen u_dut32 (
    .clk(clk), .reset(reset), .UpdateEn(UpdateEn),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .PC_current(pc32), .pc_plus(plus32), .pend_valid(pend32),
    .pc_misaligned(mis32)
  );

  pc_gen #(.WIDTH(8), .PC_INIT(8'hF8), .EXC_VEC(8'h80), .STEP(4)) u_dut8 (
    .clk(clk), .reset(reset), .UpdateEn(UpdateEn),
    .redir_valid(redir_valid), .redir_target(redir_target[7:0]),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc[7:0]),
    .PC_current(pc8), .pc_plus(plus8), .pend_valid(pend8),
    .pc_misaligned(mis8)
  );

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] = m_init[k]; m_pend[k] = 1'b0; m_tgt[k] = '0;
      end else if (exc_req) begin
        m_pc[k] = m_vec[k]; m_pend[k] = 1'b0;
      end else if (eret_req) begin
        m_pc[k] = epc & m_mask[k]; m_pend[k] = 1'b0;
      end else if (UpdateEn) begin
        if (redir_valid)  m_pc[k] = redir_target & m_mask[k];
        else if (m_pend[k]) m_pc[k] = m_tgt[k];
        else              m_pc[k] = (m_pc[k] + 32'd4) & m_mask[k];
        m_pend[k] = 1'b0;
      end else if (redir_valid) begin
        m_tgt[k] = redir_target & m_mask[k]; m_pend[k] = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pc32",   pc32, m_pc[0]);
    check("plus32", plus32, m_pc[0] + 32'd4);
    check("pend32", {31'b0, pend32}, {31'b0, m_pend[0]});
    check("mis32",  {31'b0, mis32}, {31'b0, (m_pc[0][1:0] != 2'b00)});
    check("pc8",    {24'b0, pc8}, m_pc[1]);
    check("plus8",  {24'b0, plus8}, (m_pc[1] + 32'd4) & 32'hFF);
    check("pend8",  {31'b0, pend8}, {31'b0, m_pend[1]});
    check("mis8",   {31'b0, mis8}, {31'b0, (m_pc[1][1:0] != 2'b00)});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic drive(input logic rst, input logic en, input logic rv,
                       input logic [31:0] rt, input logic ex, input logic er,
                       input logic [31:0] ep);
    reset = rst; UpdateEn = en; redir_valid = rv; redir_target = rt;
    exc_req = ex; eret_req = er; epc = ep;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = '0; m_tgt[k] = '0; m_pend[k] = 1'b0;
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    tick();
    check("reset_pc32", pc32, 32'h3000);
    check("reset_plus32", plus32, 32'h3004);
    check("reset_pc8", {24'b0, pc8}, 32'hF8);

    // sequential advance; 8-bit instance wraps F8 -> FC -> 00
    drive(0, 1, 0, 0, 0, 0, 0);
    tick(); tick();
    check("wrap_pc8", {24'b0, pc8}, 32'h00);
    tick();
    check("seq_pc32", pc32, 32'h300C);
    tick();

    // plain stall at 0x3010
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    check("stall_pc32", pc32, 32'h3010);

    // two redirects during stall; latest wins on release
    drive(0, 0, 1, 32'h3100, 0, 0, 0);
    tick();
    drive(0, 0, 1, 32'h3200, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    check("release_pc32", pc32, 32'h3200);
    tick();
    check("release_next32", pc32, 32'h3204);

    // exception beats eret and redirect, and clears the pending entry
    drive(0, 0, 1, 32'h3300, 0, 0, 0);
    tick();
    drive(0, 0, 1, 32'h3400, 1, 1, 32'h3050);
    tick();
    check("exc_pc32", pc32, 32'h4180);
    drive(0, 0, 0, 0, 0, 1, 32'h3050);
    tick();
    check("eret_pc32", pc32, 32'h3050);

    // misaligned redirect loaded unmodified
    drive(0, 1, 1, 32'h3002, 0, 0, 0);
    tick();
    check("mis_pc8", {24'b0, pc8}, 32'h02);
    check("mis_flag8", {31'b0, mis8}, 32'h1);

    // reset while a redirect is buffered
    drive(0, 0, 1, 32'h3500, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    check("post_reset_pc32", pc32, 32'h3004);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, t,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            {$urandom} & 32'hFFFF_FFFC);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the pipelined MIPS core. It holds the fetch PC and selects the next one from these sources: sequential increment, branch/jump redirect, exception entry and ERET return. It also holds a one-entry pending-redirect buffer, so a redirect that arrives while fetch is stalled is applied when the stall releases instead of being lost. The block sits between the IF-stage instruction memory address port and the ID-stage branch/jump resolution logic.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits (≥ 3)
- PC_INIT, 32'h0000_3000, PC value loaded on reset
- EXC_VEC, 32'h0000_4180, exception/interrupt entry address
- STEP, 4, sequential increment in bytes

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- UpdateEn  in  1  1 = fetch may advance; 0 = stall
- redir_valid  in  1  branch/jump redirect request from ID
- redir_target  in  WIDTH  redirect address
- exc_req  in  1  exception/interrupt entry request
- eret_req  in  1  return-from-exception request
- epc  in  WIDTH  return address for ERET
- PC_current  out  WIDTH  registered fetch PC
- pc_plus  out  WIDTH  combinational PC_current + STEP
- pend_valid  out  1  registered; a redirect is buffered
- pc_misaligned  out  1  combinational; PC_current[1:0] != 0

## Operation
- Reset, sampled at posedge clk while reset=1, takes priority over everything: PC_current <= PC_INIT, pend_valid <= 0, pending target <= 0. Reset mid-stall discards any buffered redirect.
- Next-PC priority, evaluated each cycle when not in reset:
  1. exc_req=1: PC <= EXC_VEC. Pending is cleared. Acts regardless of UpdateEn.
  2. eret_req=1: PC <= epc. Pending is cleared. Acts regardless of UpdateEn.
  3. UpdateEn=1 and redir_valid=1: PC <= redir_target. Pending is cleared, so the new redirect supersedes the buffered one.
  4. UpdateEn=1 and pend_valid=1: PC <= buffered target. Pending is cleared.
  5. UpdateEn=1: PC <= PC_current + STEP.
  6. UpdateEn=0 and redir_valid=1: PC holds. Pending target <= redir_target and pend_valid <= 1. This overwrites an existing entry; the latest redirect wins.
  7. UpdateEn=0 otherwise: PC and pending hold.
- exc_req and eret_req asserted together: the exception wins.
- Arithmetic is modulo 2^WIDTH. The increment from 2^WIDTH−STEP wraps to 0 with no flag.
- Targets are loaded unmodified. Misaligned values are reported through pc_misaligned and are not corrected; the exception logic downstream consumes the flag.
- pend_valid never asserts in a cycle where PC changes due to a redirect source.

## Timing
- All state updates on posedge clk. PC_current and pend_valid are flop outputs.
- pc_plus and pc_misaligned are combinational from PC_current, valid in the same cycle.
- Redirect latency: request in cycle N with UpdateEn=1 means PC_current = target in cycle N+1.
- Stalled redirect: buffered at the N edge, applied at the first edge with UpdateEn=1. With no new redirect in between, the target is visible the cycle after the stall releases.
- Exception/ERET latency is one cycle, independent of stall.
- Reset values: PC_current=PC_INIT, pend_valid=0, pc_plus=PC_INIT+STEP, pc_misaligned=0 (for the default PC_INIT).

## Test plan
- Reset, then UpdateEn=1 for 3 cycles -> PC_current 0x3000, 0x3004, 0x3008, 0x300C. pc_plus is 4 ahead each cycle.
- Stall: UpdateEn=0 for 4 cycles at 0x3010 -> PC_current stays 0x3010, pend_valid=0.
- Redirect during stall: UpdateEn=0 with redir 0x3100, then redir 0x3200 while still stalled, then release -> pend_valid=1 from the first edge, and the pending target becomes 0x3200. After release: PC_current=0x3200, pend_valid=0, then 0x3204.
- Exception precedence: exc_req=1, eret_req=1 and redir_valid=1 with UpdateEn=0 and a pending entry -> next PC_current=0x4180, pend_valid=0. Then eret_req=1 with epc=0x3050 -> PC_current=0x3050.
- Wrap/misalign with WIDTH=8, PC_INIT=8'hF8, STEP=4: PC goes F8 -> FC -> 00. Redirect to 8'h02 -> PC_current=02, pc_misaligned=1.
- Reset mid-stall with pend_valid=1 -> PC_current=PC_INIT and pend_valid=0 next cycle. The buffered target is never applied.
